// File: rtl/quad_step_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : quad_step_decoder
//  Purpose  : Synchronises and glitch-filters two quadrature pins, decodes x4
//             Gray-code steps into one-cycle inc/dec pulses, and flags illegal
//             double-bit transitions with a saturating error count.
//  Revision : 1.0 - initial release
// ============================================================================
module quad_step_decoder #(
    parameter int FILT_LEN = 3,   // edges a new value must hold (1..15)
    parameter int ERR_W    = 8    // width of err_cnt
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             en,
    input  logic             err_clr,
    output logic             inc,
    output logic             dec,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             locked
);

    localparam logic [3:0] c_FILT_LEN = 4'(FILT_LEN);
    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_f;
    logic [1:0]       r_cand;
    logic [3:0]       r_hold;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_upd;
    logic [1:0]       r_old;
    logic             r_inc;
    logic             r_dec;
    logic             r_err;
    logic             r_locked;
    logic [ERR_W-1:0] r_err_cnt;

    logic [3:0]       w_hold_nxt;
    logic             w_accept;
    logic             w_locked_nxt;
    logic             w_run_step;
    logic [1:0]       w_fwd_tgt;
    logic [1:0]       w_rev_tgt;
    logic             w_inc_nxt;
    logic             w_dec_nxt;
    logic             w_err_nxt;

    // Hold count of the synchronised value: restarts on any change, saturates.
    always_comb begin
        w_hold_nxt = 4'd1;
        if (r_s2 == r_cand) begin
            w_hold_nxt = (r_hold == 4'hF) ? 4'hF : r_hold + 4'd1;
        end
        // In INIT the first stable value is taken even if it equals f.
        w_accept = (w_hold_nxt >= c_FILT_LEN) &&
                   ((r_state == c_ST_INIT) || (r_s2 != r_f));
    end

    // Two-flop synchroniser followed by the hold-time filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 2'b00;
            r_s2   <= 2'b00;
            r_f    <= 2'b00;
            r_cand <= 2'b00;
            r_hold <= 4'd0;
        end else begin
            r_s1   <= {a, b};
            r_s2   <= r_s1;
            r_cand <= r_s2;
            r_hold <= w_hold_nxt;
            if (w_accept) begin
                r_f <= r_s2;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave INIT once the first pin state is captured.
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == c_ST_INIT) && w_accept) begin
            w_state_nxt = c_ST_RUN;
        end
    end

    // FSM outputs: lock indication and which filter updates count as steps.
    always_comb begin
        w_locked_nxt = (r_state == c_ST_RUN);
        w_run_step   = (r_state == c_ST_RUN) && w_accept;
    end

    // Remember the previous filtered value for decoding one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd <= 1'b0;
            r_old <= 2'b00;
        end else begin
            r_upd <= w_run_step;
            r_old <= r_f;
        end
    end

    // Gray-code decode of old->new filtered value, gated by en.
    always_comb begin
        w_fwd_tgt = 2'b01;
        w_rev_tgt = 2'b10;
        case (r_old)
            2'b00: begin w_fwd_tgt = 2'b01; w_rev_tgt = 2'b10; end
            2'b01: begin w_fwd_tgt = 2'b11; w_rev_tgt = 2'b00; end
            2'b11: begin w_fwd_tgt = 2'b10; w_rev_tgt = 2'b01; end
            default: begin w_fwd_tgt = 2'b00; w_rev_tgt = 2'b11; end
        endcase
        w_inc_nxt = en && r_upd && (r_f == w_fwd_tgt);
        w_dec_nxt = en && r_upd && (r_f == w_rev_tgt);
        w_err_nxt = en && r_upd && ((r_old ^ r_f) == 2'b11);
    end

    // Registered pulses, lock flag and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_inc    <= w_inc_nxt;
            r_dec    <= w_dec_nxt;
            r_err    <= w_err_nxt;
            r_locked <= w_locked_nxt;
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_err_nxt && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign inc     = r_inc;
    assign dec     = r_dec;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;
    assign locked  = r_locked;

`ifdef ASSERT_ON
    a_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0({inc, dec, err}));
    a_no_pulse_unlocked : assert property (@(posedge clk) disable iff (rst)
        !locked |-> !(inc || dec || err));
    a_cnt_known : assert property (@(posedge clk) disable iff (rst)
        !$isunknown(err_cnt));
    a_cnt_monotonic : assert property (@(posedge clk) disable iff (rst)
        (!$past(rst) && !$past(err_clr)) |-> (err_cnt >= $past(err_cnt)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_quad_step_decoder
//  Purpose  : Directed self-checking bench for quad_step_decoder with an
//             expected-pulse scoreboard keyed on cycle number.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quad_step_decoder;

    localparam int FILT_LEN = 3;
    localparam int ERR_W    = 8;
    localparam logic [2:0] c_INC  = 3'b100;
    localparam logic [2:0] c_DEC  = 3'b010;
    localparam logic [2:0] c_ERR  = 3'b001;
    localparam logic [2:0] c_NONE = 3'b000;

    logic             clk = 1'b0;
    logic             rst;
    logic             a;
    logic             b;
    logic             en;
    logic             err_clr;
    logic             inc;
    logic             dec;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic             locked;

    typedef struct {
        int         cyc;
        logic [2:0] code;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] cnt8   = 8'd0;

    quad_step_decoder #(.FILT_LEN(FILT_LEN), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .en      (en),
        .err_clr (err_clr),
        .inc     (inc),
        .dec     (dec),
        .err     (err),
        .err_cnt (err_cnt),
        .locked  (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a pin pair, record the pulse it should produce, hold it.
    task automatic step(input logic [1:0] ab, input int hold, input logic [2:0] code);
        if (code != c_NONE) q.push_back(exp_t'{cyc + FILT_LEN + 3, code});
        {a, b} = ab;
        tick(hold);
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        logic [2:0] code;
        exp_t       e;
        code = {inc, dec, err};
        if (code !== c_NONE) begin
            chk("pulse_locked", locked, 1);
            if (q.size() == 0) begin
                chk("unexpected_pulse", code, c_NONE);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_kind", code, e.code);
            end
            if (inc) cnt8 = cnt8 + 8'd1;
            if (dec) cnt8 = cnt8 - 8'd1;
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; err_clr = 1'b0; {a, b} = 2'b11;
        tick(3);
        chk("rst_inc", inc, 0);
        chk("rst_dec", dec, 0);
        chk("rst_err", err, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Lock onto 11 after reset release.
        rst = 1'b0;
        tick(5);
        chk("locked_early", locked, 0);
        tick(1);
        chk("locked_c6", locked, 1);
        tick(4);
        chk("init_no_pulse", q.size(), 0);

        // Walk from 11 back to 00 (proves f captured 11).
        step(2'b10, 8, c_INC);
        step(2'b00, 8, c_INC);
        chk("init_walk_done", q.size(), 0);
        cnt8 = 8'd0;

        // Forward sequence.
        step(2'b01, 8, c_INC);
        step(2'b11, 8, c_INC);
        step(2'b10, 8, c_INC);
        step(2'b00, 8, c_INC);
        chk("fwd_done", q.size(), 0);
        chk("fwd_count", cnt8, 4);

        // Reverse sequence and 8-bit wrap.
        step(2'b10, 8, c_DEC);
        step(2'b11, 8, c_DEC);
        step(2'b01, 8, c_DEC);
        step(2'b00, 8, c_DEC);
        chk("rev_count", cnt8, 0);
        step(2'b10, 8, c_DEC);
        chk("wrap_count", cnt8, 255);
        step(2'b00, 8, c_INC);
        chk("unwrap_count", cnt8, 0);

        // Glitch shorter than the filter, then a minimum-length hold.
        step(2'b01, 2, c_NONE);
        step(2'b00, 8, c_NONE);
        chk("glitch_filtered", q.size(), 0);
        step(2'b01, 3, c_INC);
        step(2'b11, 8, c_INC);
        step(2'b10, 8, c_INC);
        step(2'b00, 8, c_INC);
        chk("min_hold_done", q.size(), 0);

        // Illegal double-bit transitions until the counter saturates.
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? 2'b11 : 2'b00, 8, c_ERR);
            chk("err_cnt_sat", err_cnt, (i + 1 > 255) ? 255 : i + 1);
        end
        chk("err_loop_done", q.size(), 0);

        // err_clr on the same edge that registers an err pulse.
        q.push_back(exp_t'{cyc + FILT_LEN + 3, c_ERR});
        {a, b} = 2'b11;
        tick(5);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr_prio", err_cnt, 0);
        tick(2);
        step(2'b00, 8, c_ERR);
        chk("err_cnt_after_clr", err_cnt, 1);

        // en low: steps and an illegal move are tracked silently.
        en = 1'b0;
        step(2'b01, 8, c_NONE);
        step(2'b11, 8, c_NONE);
        step(2'b00, 8, c_NONE);
        chk("en_low_err_cnt", err_cnt, 1);
        en = 1'b1;
        tick(8);
        chk("reenable_quiet", q.size(), 0);
        step(2'b01, 8, c_INC);
        chk("reenable_step", q.size(), 0);

        // Reset in the middle of a step.
        {a, b} = 2'b11;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("midrst_inc", inc, 0);
        chk("midrst_dec", dec, 0);
        chk("midrst_err", err, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        tick(10);
        chk("relock", locked, 1);
        step(2'b10, 8, c_INC);
        chk("final_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
